// File: rtl/moore_fsm.sv
// Moore detector for the serial pattern 1101 with overlapping matches; binary or one-hot state register.
// Optional saturating detection counter on port match_cnt, enabled by defining MOORE_FSM_MATCH_CNT_EN.
module moore_fsm #(
  parameter int ONEHOT = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  output logic             outp
`ifdef MOORE_FSM_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  logic outp_q;

`ifdef MOORE_FSM_MATCH_CNT_EN
  logic             enter_detect;
  logic [CNT_W-1:0] match_cnt_q;
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("moore_fsm: CNT_W must be at least 1");
  end

  if (ONEHOT != 0) begin : g_onehot
    typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      S1     = 5'b00010,
      S11    = 5'b00100,
      S110   = 5'b01000,
      DETECT = 5'b10000
    } state_t;

    state_t state_q;

    // outp_q is loaded with "next state is DETECT", so it always mirrors the registered state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        outp_q  <= 1'b0;
      end else begin
        outp_q <= 1'b0;
        case (state_q)
          IDLE:    state_q <= inp ? S1 : IDLE;
          S1:      state_q <= inp ? S11 : IDLE;
          S11:     state_q <= inp ? S11 : S110;
          S110: begin
            if (inp) begin
              state_q <= DETECT;
              outp_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          DETECT:  state_q <= inp ? S11 : IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end

`ifdef MOORE_FSM_MATCH_CNT_EN
    assign enter_detect = (state_q == S110) && inp;
`endif
  end else begin : g_binary
    typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S1     = 3'd1,
      S11    = 3'd2,
      S110   = 3'd3,
      DETECT = 3'd4
    } state_t;

    state_t state_q;

    // Codes 5-7 fall into the default arm and recover to IDLE with outp low.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        outp_q  <= 1'b0;
      end else begin
        outp_q <= 1'b0;
        case (state_q)
          IDLE:    state_q <= inp ? S1 : IDLE;
          S1:      state_q <= inp ? S11 : IDLE;
          S11:     state_q <= inp ? S11 : S110;
          S110: begin
            if (inp) begin
              state_q <= DETECT;
              outp_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          DETECT:  state_q <= inp ? S11 : IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end

`ifdef MOORE_FSM_MATCH_CNT_EN
    assign enter_detect = (state_q == S110) && inp;
`endif
  end

`ifdef MOORE_FSM_MATCH_CNT_EN
  // Counts on the same edge that enters DETECT and sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt_q <= '0;
    end else if (enter_detect && (match_cnt_q != {CNT_W{1'b1}})) begin
      match_cnt_q <= match_cnt_q + 1'b1;
    end
  end

  assign match_cnt = match_cnt_q;
`endif

  assign outp = outp_q;

endmodule

// File: tb/tb_moore_fsm.sv
// Bench for moore_fsm: binary and one-hot instances driven in lockstep against a sliding-window reference.
// The model flags a detection whenever the last four samples since reset read 1101.
module tb_moore_fsm;

  logic clk = 1'b0;
  logic rst;
  logic inp;
  logic outp_b;
  logic outp_h;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef MOORE_FSM_MATCH_CNT_EN
  logic [7:0] cnt_b;
  logic [7:0] cnt_h;
  logic [1:0] cnt_s;
`endif

  moore_fsm #(.ONEHOT(0), .CNT_W(8)) dut_bin (
    .clk(clk), .rst(rst), .inp(inp), .outp(outp_b)
`ifdef MOORE_FSM_MATCH_CNT_EN
    , .match_cnt(cnt_b)
`endif
  );

  moore_fsm #(.ONEHOT(1), .CNT_W(8)) dut_oh (
    .clk(clk), .rst(rst), .inp(inp), .outp(outp_h)
`ifdef MOORE_FSM_MATCH_CNT_EN
    , .match_cnt(cnt_h)
`endif
  );

`ifdef MOORE_FSM_MATCH_CNT_EN
  logic outp_s;
  moore_fsm #(.ONEHOT(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .inp(inp), .outp(outp_s), .match_cnt(cnt_s)
  );
`endif

  // Reference: sample history since the last reset plus saturating detection tallies.
  logic [3:0] m_hist;
  int         m_n;
  logic       m_out;
  int         m_cnt8;
  int         m_cnt2;

  task automatic m_reset();
    m_hist = 4'b0000;
    m_n    = 0;
    m_out  = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  task automatic m_sample(input logic b);
    m_hist = {m_hist[2:0], b};
    if (m_n < 4) m_n = m_n + 1;
    m_out = (m_n >= 4) && (m_hist == 4'b1101);
    if (m_out) begin
      if (m_cnt8 < 255) m_cnt8 = m_cnt8 + 1;
      if (m_cnt2 < 3)   m_cnt2 = m_cnt2 + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_outp_bin"}, {31'd0, outp_b}, {31'd0, m_out});
    check({tag, "_outp_oh"},  {31'd0, outp_h}, {31'd0, m_out});
    check({tag, "_trace_eq"}, {31'd0, outp_h}, {31'd0, outp_b});
`ifdef MOORE_FSM_MATCH_CNT_EN
    check({tag, "_cnt_bin"}, {24'd0, cnt_b}, m_cnt8);
    check({tag, "_cnt_oh"},  {24'd0, cnt_h}, m_cnt8);
    check({tag, "_cnt_sat"}, {30'd0, cnt_s}, m_cnt2);
`endif
  endtask

  // Entered and left at posedge+1: drive on the falling edge, sample just after the rising edge.
  task automatic step(input logic b);
    @(negedge clk);
    inp = b;
    @(posedge clk);
    #1;
    m_sample(b);
    check_all("step");
    $display("step in=%0b outp_bin=%0b outp_oh=%0b expected=%0b", b, outp_b, outp_h, m_out);
  endtask

  task automatic step_seq(input logic [15:0] bits, input int len);
    for (int k = len - 1; k >= 0; k--) step(bits[k]);
  endtask

  // Asserts reset between edges, holds it for 'hold' edges with inp toggling, releases at posedge+1.
  task automatic do_reset(input int hold);
    #1;
    rst = 1'b0;
    #1;
    m_reset();
    check_all("rst_async");
    $display("reset asserted outp_bin=%0b outp_oh=%0b", outp_b, outp_h);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      inp = ~inp;
      @(posedge clk);
      #1;
      check_all("rst_hold");
      $display("reset hold in=%0b outp_bin=%0b outp_oh=%0b", inp, outp_b, outp_h);
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    inp = 1'b0;
    m_reset();
    #1;
    check_all("por");
    @(posedge clk);
    #1;

    do_reset(2);
    step_seq(16'b1101, 4);
    check("pulse_after_4th", {31'd0, outp_b}, 32'd1);
    step(1'b0);
    check("pulse_one_cycle", {31'd0, outp_b}, 32'd0);

    do_reset(1);
    step_seq(16'b1101101, 7);
`ifdef MOORE_FSM_MATCH_CNT_EN
    check("two_matches", {24'd0, cnt_b}, 32'd2);
`endif

    do_reset(1);
    step_seq(16'b11101, 5);
    check("pulse_after_5th", {31'd0, outp_h}, 32'd1);
    do_reset(1);
    step_seq(16'b101100, 6);

    // Reset landing while outp is high must drop it without waiting for a clock.
    do_reset(1);
    step_seq(16'b1101, 4);
    do_reset(0);
    check("rst_kills_pulse", {31'd0, outp_b}, 32'd0);

    do_reset(1);
    step_seq(16'b1101110111011101, 16);
    step_seq(16'b1101, 4);
`ifdef MOORE_FSM_MATCH_CNT_EN
    check("sat_holds_3", {30'd0, cnt_s}, 32'd3);
`endif

    // Partial match 110 must be forgotten across reset.
    do_reset(1);
    step_seq(16'b110, 3);
    do_reset(0);
    step(1'b1);
    check("no_stale_match", {31'd0, outp_b}, 32'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset(int'($urandom_range(0, 2)));
      end else begin
        step($urandom_range(0, 3) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
